// File: rtl/output_mems.sv
`default_nettype none
// ============================================================================
// Module   : output_mems (with helper memory)
// Purpose  : Buffers the convolution output Y and streams it row-major as an
//            AXI-Stream master once the compute engine signals completion.
// Revision : 1.0
// ============================================================================

module memory #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 168,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 write_en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     write_data,
  output logic [WIDTH-1:0]     read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Addresses past DEPTH (e.g. the read-ahead on the final beat) are dropped.
  always_ff @(posedge clk) begin
    if (32'(addr) < DEPTH) begin
      if (write_en) mem[addr] <= write_data;
      read_data <= mem[addr];
    end
  end

endmodule

module output_mems #(
  parameter  int OUTW        = 32,
  parameter  int R           = 15,
  parameter  int C           = 13,
  parameter  int MAXK        = 7,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int Y_DEPTH     = (R - 1) * (C - 1),
  localparam int Y_ADDR_BITS = $clog2(Y_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [K_BITS-1:0]      K,
  input  logic [OUTW-1:0]        Y_write_data,
  input  logic [Y_ADDR_BITS-1:0] Y_write_addr,
  input  logic                   Y_write_en,
  input  logic                   results_ready,
  output logic                   output_busy,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY,
  output logic                   AXIS_TLAST,
  output logic                   tx_done
);

  localparam logic [Y_ADDR_BITS:0]   N_ONE   = (Y_ADDR_BITS + 1)'(1);
  localparam logic [Y_ADDR_BITS:0]   N_TWO   = (Y_ADDR_BITS + 1)'(2);
  localparam logic [Y_ADDR_BITS-1:0] IDX_ONE = Y_ADDR_BITS'(1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                 state;
  logic [Y_ADDR_BITS-1:0] idx;
  logic [Y_ADDR_BITS:0]   n;
  logic [Y_ADDR_BITS:0]   n_calc;
  logic [K_BITS-1:0]      keff;
  logic [Y_ADDR_BITS-1:0] rd_addr;
  logic [Y_ADDR_BITS-1:0] mem_addr;
  logic                   mem_we;
  logic                   beat;
  logic                   last;

  always_comb begin
    keff = K;
    if (K < K_BITS'(2))
      keff = K_BITS'(2);
    else if (32'(K) > MAXK)
      keff = K_BITS'(MAXK);
  end

  assign n_calc = (Y_ADDR_BITS + 1)'((R - int'(keff) + 1) * (C - int'(keff) + 1));

  assign beat     = AXIS_TVALID & AXIS_TREADY;
  assign last     = ({1'b0, idx} == (n - N_ONE));
  // Reading one ahead on a beat keeps TDATA aligned with idx; a stall holds it.
  assign rd_addr  = beat ? (idx + IDX_ONE) : idx;
  assign mem_addr = (state == FILL) ? Y_write_addr : rd_addr;
  assign mem_we   = (state == FILL) & Y_write_en;

  memory #(
    .WIDTH    (OUTW),
    .DEPTH    (Y_DEPTH),
    .ADDR_BITS(Y_ADDR_BITS)
  ) u_mem (
    .clk       (clk),
    .write_en  (mem_we),
    .addr      (mem_addr),
    .write_data(Y_write_data),
    .read_data (AXIS_TDATA)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      idx         <= '0;
      n           <= '0;
      AXIS_TVALID <= 1'b0;
      AXIS_TLAST  <= 1'b0;
      tx_done     <= 1'b0;
      output_busy <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        FILL: begin
          if (results_ready) begin
            n           <= n_calc;
            idx         <= '0;
            output_busy <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          AXIS_TVALID <= 1'b1;
          AXIS_TLAST  <= (n == N_ONE);
          state       <= STREAM;
        end
        STREAM: begin
          if (beat) begin
            if (last) begin
              AXIS_TVALID <= 1'b0;
              AXIS_TLAST  <= 1'b0;
              output_busy <= 1'b0;
              tx_done     <= 1'b1;
              state       <= FILL;
            end else begin
              idx        <= idx + IDX_ONE;
              AXIS_TLAST <= (({1'b0, idx} + N_TWO) == n);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_mems.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_mems
// Purpose  : Self-checking bench for output_mems (frame table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_output_mems;

  localparam int OUTW  = 32;
  localparam int R     = 15;
  localparam int C     = 13;
  localparam int KB    = 3;
  localparam int AB    = 8;
  localparam int DEPTH = 168;
  localparam int NVEC  = 13;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [KB-1:0]   K = '0;
  logic [OUTW-1:0] wdata = '0;
  logic [AB-1:0]   waddr = '0;
  logic            we = 1'b0;
  logic            rr1 = 1'b0;
  logic            rr2 = 1'b0;
  logic            tready = 1'b0;
  logic            sel = 1'b0;

  logic            busy1, tv1, tl1, txd1;
  logic            busy2, tv2, tl2, txd2;
  logic [OUTW-1:0] td1, td2;
  logic            busy, tv, tl, txd;
  logic [OUTW-1:0] td;

  always #5 clk = ~clk;

  output_mems #(.OUTW(OUTW), .R(R), .C(C), .MAXK(7)) u_dut (
    .clk(clk), .reset(reset), .K(K), .Y_write_data(wdata), .Y_write_addr(waddr),
    .Y_write_en(we), .results_ready(rr1), .output_busy(busy1), .AXIS_TDATA(td1),
    .AXIS_TVALID(tv1), .AXIS_TREADY(tready), .AXIS_TLAST(tl1), .tx_done(txd1)
  );

  // Second instance with a smaller MAXK to exercise clamping from above.
  output_mems #(.OUTW(OUTW), .R(R), .C(C), .MAXK(5)) u_dut5 (
    .clk(clk), .reset(reset), .K(K), .Y_write_data(wdata), .Y_write_addr(waddr),
    .Y_write_en(we), .results_ready(rr2), .output_busy(busy2), .AXIS_TDATA(td2),
    .AXIS_TVALID(tv2), .AXIS_TREADY(tready), .AXIS_TLAST(tl2), .tx_done(txd2)
  );

  assign busy = sel ? busy2 : busy1;
  assign tv   = sel ? tv2   : tv1;
  assign tl   = sel ? tl2   : tl1;
  assign txd  = sel ? txd2  : txd1;
  assign td   = sel ? td2   : td1;

  typedef struct {
    int k;
    bit use2;
    int mode;      // 0: TREADY always 1, 1: TREADY pattern 1,0,0
    int inject;    // beat number carrying ignored write/results_ready (0 = none)
    int abort_at;  // reset after this many beats (0 = none)
    bit b2b;       // next entry starts from results_ready in the tx_done cycle
    bit wr0;       // write Y[0] in the same cycle as results_ready
    int n;
  } vec_t;

  typedef struct {
    int d;
    bit l;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];
  int   ymem [DEPTH];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (time %0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        v;
    exp_t        ex;
    int          cyc, beats, last_cyc;
    bit          r, stalled, done, chained, aborted, bad;
    logic [31:0] pd;
    logic        pl;

    vecs[0]  = '{3, 1'b0, 0, 0, 0,  1'b0, 1'b0, 143}; // basic
    vecs[1]  = '{3, 1'b0, 1, 0, 0,  1'b0, 1'b0, 143}; // backpressure
    vecs[2]  = '{2, 1'b0, 0, 0, 0,  1'b0, 1'b0, 168};
    vecs[3]  = '{7, 1'b0, 0, 0, 0,  1'b0, 1'b0, 63};
    vecs[4]  = '{0, 1'b0, 0, 0, 0,  1'b0, 1'b0, 168}; // K=0 -> 2
    vecs[5]  = '{7, 1'b1, 0, 0, 0,  1'b0, 1'b0, 99};  // MAXK=5 clamp
    vecs[6]  = '{3, 1'b0, 0, 5, 0,  1'b0, 1'b0, 143}; // ignored inputs
    vecs[7]  = '{3, 1'b0, 0, 0, 0,  1'b0, 1'b0, 143}; // old Y[0] kept
    vecs[8]  = '{3, 1'b0, 0, 0, 10, 1'b0, 1'b0, 143}; // reset mid-stream
    vecs[9]  = '{3, 1'b0, 0, 0, 0,  1'b1, 1'b0, 143}; // restarts at Y[0]
    vecs[10] = '{4, 1'b0, 0, 0, 0,  1'b0, 1'b0, 120}; // back-to-back
    vecs[11] = '{1, 1'b0, 1, 0, 0,  1'b0, 1'b0, 168}; // K=1 -> 2
    vecs[12] = '{7, 1'b0, 0, 0, 0,  1'b0, 1'b1, 63};  // write with results_ready

    repeat (2) tick();
    chk("rst_tvalid", 64'(tv1), 0);
    chk("rst_tlast", 64'(tl1), 0);
    chk("rst_tx_done", 64'(txd1), 0);
    chk("rst_busy", 64'(busy1), 0);
    chk("rst_tvalid5", 64'(tv2), 0);
    chk("rst_busy5", 64'(busy2), 0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; waddr = AB'(i); wdata = OUTW'(i - 71); ymem[i] = i - 71;
      tick();
    end
    we = 1'b0;

    chained = 1'b0;
    for (int e = 0; e < NVEC; e++) begin
      v = vecs[e];
      sel = v.use2;
      if (!chained) begin
        K = KB'(v.k);
        if (v.wr0) begin
          we = 1'b1; waddr = '0; wdata = OUTW'(1234); ymem[0] = 1234;
        end
        if (v.use2) rr2 = 1'b1; else rr1 = 1'b1;
        tick();
        rr1 = 1'b0; rr2 = 1'b0; we = 1'b0;
        chk("load_busy", 64'(busy), 1);
        chk("load_tvalid", 64'(tv), 0);
        tick();
      end
      chained = 1'b0;

      for (int j = 0; j < v.n; j++) sb.push_back(exp_t'{ymem[j], (j == v.n - 1)});
      cyc = 0; beats = 0; last_cyc = 0;
      stalled = 1'b0; done = 1'b0; aborted = 1'b0; bad = 1'b0;
      pd = '0; pl = 1'b0;

      while (!done) begin
        cyc++;
        if (cyc > 3 * v.n + 20) begin
          chk("timeout", 0, 1);
          sb.delete(); bad = 1'b1; done = 1'b1;
          break;
        end
        chk("tvalid_held", 64'(tv), 1);
        if (stalled) begin
          chk("stall_tdata", longint'($signed(td)), longint'($signed(pd)));
          chk("stall_tlast", 64'(tl), 64'(pl));
        end
        r = (v.mode == 0) || (((cyc - 1) % 3) == 0);
        tready = r;
        if (v.inject != 0 && beats == v.inject - 1) begin
          we = 1'b1; waddr = '0; wdata = 32'h7FFF; rr1 = 1'b1;
        end
        if (tv && r) begin
          beats++;
          ex = sb.pop_front();
          chk("tdata", longint'($signed(td)), longint'(ex.d));
          chk("tlast", 64'(tl), 64'(ex.l));
          stalled = 1'b0;
          if (sb.size() == 0) begin
            last_cyc = cyc;
            done = 1'b1;
          end
        end else begin
          stalled = tv; pd = td; pl = tl;
        end
        tick();
        we = 1'b0; rr1 = 1'b0;
        if (v.abort_at != 0 && beats == v.abort_at && !done) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          chk("abort_tvalid", 64'(tv), 0);
          chk("abort_busy", 64'(busy), 0);
          sb.delete();
          aborted = 1'b1; done = 1'b1;
        end
      end
      tready = 1'b0;

      if (!aborted && !bad) begin
        chk("done_tx_done", 64'(txd), 1);
        chk("done_tvalid", 64'(tv), 0);
        chk("done_busy", 64'(busy), 0);
        chk("done_tlast", 64'(tl), 0);
        chk("last_beat_cycle", last_cyc, (v.mode == 0) ? v.n : 3 * (v.n - 1) + 1);
        if (v.b2b && e + 1 < NVEC) begin
          K = KB'(vecs[e + 1].k);
          rr1 = 1'b1;
          tick();
          rr1 = 1'b0;
          chk("b2b_load_busy", 64'(busy), 1);
          chk("b2b_load_tvalid", 64'(tv), 0);
          chk("tx_done_pulse", 64'(txd), 0);
          tick();
          chained = 1'b1;
        end else begin
          tick();
          chk("tx_done_pulse", 64'(txd), 0);
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
